// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the single-step Fibonacci function used by the
// unrolled word generator (LFSR_LOCKUP_RECOVER_EN selects zero-seed recovery in the top).
package lfsr_pkg;

    localparam int MAX_W = 64;

    // Fibonacci tap masks: bit i set means state[i] feeds the XOR.
    localparam logic [7:0]  POLY_8  = 8'hB8;
    localparam logic [15:0] POLY_16 = 16'hB400;
    localparam logic [22:0] POLY_23 = 23'h420000;
    localparam logic [30:0] POLY_31 = 31'h48000000;

    typedef struct packed {
        logic [MAX_W-1:0] state;
        logic             out_bit;
    } step_t;

    // One shift: emit state[width-1], shift left, insert parity of tapped bits.
    function automatic step_t lfsr_step(
        input logic [MAX_W-1:0] state,
        input logic [MAX_W-1:0] poly,
        input int unsigned      width
    );
        step_t            r;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] top;
        logic             fb;
        mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        top  = state >> (width - 1);
        fb   = ^(state & poly & mask);
        r.out_bit = top[0];
        r.state   = ((state << 1) | {{(MAX_W-1){1'b0}}, fb}) & mask;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational OUT_W-deep chain of LFSR steps producing one output word
// (first produced bit in the MSB) and the state after the last step.
module lfsr_step_unroll
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = POLY_8,
    parameter int               OUT_W = 8
) (
    input  logic [WIDTH-1:0] state,
    output logic [OUT_W-1:0] word,
    output logic [WIDTH-1:0] next_state
);

    localparam logic [MAX_W-1:0] POLY_EXT = MAX_W'(POLY);

    logic [WIDTH-1:0] cur;
    step_t            st;

    always_comb begin
        cur  = state;
        word = '0;
        st   = '0;
        for (int i = 0; i < OUT_W; i++) begin
            st                = lfsr_step(MAX_W'(cur), POLY_EXT, WIDTH);
            word[OUT_W-1-i]   = st.out_bit;
            cur               = WIDTH'(st.state);
        end
        next_state = cur;
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Multi-bit Fibonacci LFSR pattern generator with seed load, valid/ready output,
// wrap detection and lockup flag. Define LFSR_LOCKUP_RECOVER_EN for zero-seed recovery.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = POLY_8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic [WIDTH-1:0] state_out,
    output logic             wrap,
    output logic             lock_err
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
            $error("lfsr_prbs_gen: WIDTH out of range");
        end
        if (OUT_W < 1 || OUT_W > MAX_W) begin : g_bad_out_w
            $error("lfsr_prbs_gen: OUT_W out of range");
        end
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_prbs_gen: SEED must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0] state_p0;
    logic [WIDTH-1:0] seed_p0;
    logic [OUT_W-1:0] word;
    logic [WIDTH-1:0] next_state;
    logic             advance;
    logic             load_zero;
    logic [WIDTH-1:0] load_val;

    lfsr_step_unroll #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .OUT_W (OUT_W)
    ) u_unroll (
        .state      (state_p0),
        .word       (word),
        .next_state (next_state)
    );

    // A new word may be produced when the output slot is empty or being emptied.
    assign advance   = en && !ld && (!out_valid || out_ready);
    assign load_zero = (seed_in == '0);

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign load_val = load_zero ? SEED : seed_in;
`else
    assign load_val = seed_in;
`endif

    assign state_out = state_p0;

    // Stage p0: LFSR state, loaded seed, output word and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0  <= SEED;
            seed_p0   <= SEED;
            out_valid <= 1'b0;
            dout      <= '0;
            wrap      <= 1'b0;
        end else if (ld) begin
            state_p0  <= load_val;
            seed_p0   <= load_val;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (advance) begin
            state_p0  <= next_state;
            dout      <= word;
            out_valid <= 1'b1;
            wrap      <= (next_state == seed_p0);
        end else begin
            wrap <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Lockup flag: sticky until a nonzero load, or a single-cycle pulse in recovery mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_err <= 1'b0;
        end else begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            lock_err <= ld && load_zero;
`else
            if (ld) begin
                lock_err <= load_zero;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench for lfsr_prbs_gen: directed scenarios plus randomized
// traffic against a word-level reference model of the 8-bit default generator.
module tb_lfsr_prbs_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] dout;
    logic [7:0] state_out;
    logic       wrap;
    logic       lock_err;

    logic       ld1 = 1'b0;
    logic [7:0] seed_in1 = 8'h00;
    logic       en1 = 1'b0;
    logic       out_ready1 = 1'b0;
    logic       out_valid1;
    logic [0:0] dout1;
    logic [7:0] state_out1;
    logic       wrap1;
    logic       lock_err1;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [7:0] m_state, m_seed, m_dout;
    logic       m_valid, m_wrap, m_lock;

    always #5 clk = ~clk;

    lfsr_prbs_gen dut (
        .clk(clk), .reset(reset), .ld(ld), .seed_in(seed_in), .en(en),
        .out_ready(out_ready), .out_valid(out_valid), .dout(dout),
        .state_out(state_out), .wrap(wrap), .lock_err(lock_err)
    );

    lfsr_prbs_gen #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h01), .OUT_W(1)) dut1 (
        .clk(clk), .reset(reset), .ld(ld1), .seed_in(seed_in1), .en(en1),
        .out_ready(out_ready1), .out_valid(out_valid1), .dout(dout1),
        .state_out(state_out1), .wrap(wrap1), .lock_err(lock_err1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Produce 8 bits by the shift rule: emitted bit is the MSB, new LSB is tap parity.
    function automatic logic [15:0] model_word(input logic [7:0] s);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w = (w << 1) | 8'(s >> 7);
            s = (s << 1) | 8'($countones(s & 8'hB8) % 2);
        end
        return {w, s};
    endfunction

    task automatic model_reset();
        m_state = 8'h01; m_seed = 8'h01; m_dout = 8'h00;
        m_valid = 1'b0; m_wrap = 1'b0; m_lock = 1'b0;
    endtask

    task automatic model_clock(input logic e, input logic r, input logic l, input logic [7:0] s);
        logic [15:0] ws;
        if (l) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            m_state = (s == 8'h00) ? 8'h01 : s;
`else
            m_state = s;
`endif
            m_seed  = m_state;
            m_valid = 1'b0;
            m_wrap  = 1'b0;
            m_lock  = (s == 8'h00);
        end else begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            m_lock = 1'b0;
`endif
            if (e && (!m_valid || r)) begin
                ws      = model_word(m_state);
                m_dout  = ws[15:8];
                m_state = ws[7:0];
                m_valid = 1'b1;
                m_wrap  = (m_state == m_seed);
            end else begin
                m_wrap = 1'b0;
                if (m_valid && r) m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ".valid"}, 64'(out_valid), 64'(m_valid));
        check_eq({ph, ".state"}, 64'(state_out), 64'(m_state));
        check_eq({ph, ".wrap"},  64'(wrap),      64'(m_wrap));
        check_eq({ph, ".lock"},  64'(lock_err),  64'(m_lock));
        if (m_valid) check_eq({ph, ".dout"}, 64'(dout), 64'(m_dout));
    endtask

    // One clock: inputs driven at the falling edge, model stepped at the rising edge,
    // outputs compared at the next falling edge.
    task automatic cyc(input string ph, input logic e, input logic r, input logic l, input logic [7:0] s);
        en = e; out_ready = r; ld = l; seed_in = s;
        @(posedge clk);
        model_clock(e, r, l, s);
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; out_ready = 1'b0; ld = 1'b0; en1 = 1'b0; out_ready1 = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("rst");
        check_eq("rst.dout", 64'(dout), 64'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] held_dout, held_state;
        int nword, nwrap;
        logic e, r, l;
        logic [7:0] s;

        model_reset();
        do_reset();

        // first word after reset, then a short free-running stream
        cyc("first", 1, 1, 0, 8'h00);
        check_eq("first_word", 64'(dout), 64'h01);
        for (int i = 0; i < 6; i++) cyc("stream", 1, 1, 0, 8'h00);

        // back-pressure: word and state must not move
        cyc("pre_hold", 1, 0, 0, 8'h00);
        held_dout = dout; held_state = state_out;
        for (int i = 0; i < 5; i++) begin
            cyc("hold", 1, 0, 0, 8'h00);
            check_eq("hold_dout", 64'(dout), 64'(held_dout));
            check_eq("hold_state", 64'(state_out), 64'(held_state));
        end
        for (int i = 0; i < 4; i++) cyc("release", 1, 1, 0, 8'h00);

        // load while a word is pending and stalled
        cyc("stall", 1, 0, 0, 8'h00);
        cyc("ld_a5", 1, 0, 1, 8'hA5);
        check_eq("ld_a5_state", 64'(state_out), 64'hA5);
        check_eq("ld_a5_valid", 64'(out_valid), 64'h0);
        for (int i = 0; i < 5; i++) cyc("after_a5", 1, 1, 0, 8'h00);

        // load together with ready: load wins
        cyc("ld_rdy", 1, 1, 1, 8'h3C);
        check_eq("ld_rdy_valid", 64'(out_valid), 64'h0);

        // zero seed
        cyc("ld_zero", 1, 1, 1, 8'h00);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check_eq("zero_recover_state", 64'(state_out), 64'h01);
        check_eq("zero_pulse", 64'(lock_err), 64'h1);
        cyc("zero_next", 1, 1, 0, 8'h00);
        check_eq("zero_pulse_gone", 64'(lock_err), 64'h0);
`else
        for (int i = 0; i < 4; i++) begin
            cyc("lockup", 1, 1, 0, 8'h00);
            check_eq("lockup_dout", 64'(dout), 64'h0);
            check_eq("lockup_sticky", 64'(lock_err), 64'h1);
        end
`endif
        cyc("ld_clear", 1, 1, 1, 8'h5A);
        check_eq("ld_clear_lock", 64'(lock_err), 64'h0);

        // drain with en=0: state frozen
        cyc("fill", 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc("drain", 0, 1, 0, 8'h00);

        // wrap for OUT_W=8: gcd(8,255)=1 so every 255 words from the seed
        cyc("wrap_ld", 0, 1, 1, 8'h01);
        nwrap = 0;
        for (int i = 0; i < 260; i++) begin
            cyc("wrap8", 1, 1, 0, 8'h00);
            if (wrap) nwrap++;
        end
        check_eq("wrap8_count", 64'(nwrap), 64'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            l = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cyc("rand", e, r, l, s);
        end

        // asynchronous reset while a stalled word is pending
        cyc("pre_rst", 1, 0, 1, 8'h77);
        cyc("pre_rst2", 1, 0, 0, 8'h00);
        check_eq("pre_rst_valid", 64'(out_valid), 64'h1);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'h0);
        check_eq("midrst_state", 64'(state_out), 64'h01);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc("post_rst", 1, 1, 0, 8'h00);
        check_eq("post_rst_first", 64'(dout), 64'h01);
        for (int i = 0; i < 5; i++) cyc("post_rst", 1, 1, 0, 8'h00);

        // single-bit instance: wrap on words 255 and 510 only
        do_reset();
        en = 1'b0;
        en1 = 1'b1; out_ready1 = 1'b1;
        nword = 0; nwrap = 0;
        for (int i = 0; i < 520; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid1) begin
                nword++;
                check_eq("wrap1", 64'(wrap1), 64'((nword % 255) == 0));
            end else begin
                check_eq("wrap1_idle", 64'(wrap1), 64'h0);
            end
            if (wrap1) nwrap++;
        end
        check_eq("wrap1_words", 64'(nword), 64'd520);
        check_eq("wrap1_count", 64'(nwrap), 64'd2);
        en1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", n_checks, -1);
        $fatal(1, "timeout");
    end

endmodule
